// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: valid/ready word in, MSB-first bit stream out.
// Optional macro PISO_PARITY_EN appends an even-parity bit to each frame.
module piso_serializer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             x_o,
  output logic             x_valid_o,
  output logic             last_o
);

`ifdef PISO_PARITY_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif
  localparam int unsigned CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] CNT_LOAD = CW'(FRAME - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [FRAME-1:0] sreg, sreg_nxt;
  logic [FRAME-1:0] frame_word;
  logic             x_nxt, x_valid_nxt, last_nxt;
  logic             accept;

`ifdef PISO_PARITY_EN
  assign frame_word = {data_i, ^data_i};
`else
  assign frame_word = data_i;
`endif

  assign ready_o = !reset && (state == IDLE || last_o);
  assign accept  = valid_i && ready_o;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // The first bit goes straight to x_o at accept, so the register holds only the remaining bits.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = '0;
    sreg_nxt    = '0;
    x_nxt       = 1'b0;
    x_valid_nxt = 1'b0;
    last_nxt    = 1'b0;
    if (accept) begin
      state_nxt   = SHIFT;
      cnt_nxt     = CNT_LOAD;
      sreg_nxt    = {frame_word[FRAME-2:0], 1'b0};
      x_nxt       = frame_word[FRAME-1];
      x_valid_nxt = 1'b1;
      last_nxt    = (CNT_LOAD == '0);
    end else if (state == SHIFT) begin
      if (last_o) begin
        state_nxt = IDLE;
      end else begin
        cnt_nxt     = cnt - CNT_ONE;
        sreg_nxt    = {sreg[FRAME-2:0], 1'b0};
        x_nxt       = sreg[FRAME-1];
        x_valid_nxt = 1'b1;
        last_nxt    = (cnt == CNT_ONE);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      sreg      <= '0;
      x_o       <= 1'b0;
      x_valid_o <= 1'b0;
      last_o    <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      sreg      <= sreg_nxt;
      x_o       <= x_nxt;
      x_valid_o <= x_valid_nxt;
      last_o    <= last_nxt;
    end
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out transmitter for the single-bit serial link. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out MSB first, one bit per clock, on `x_o`. Qualifier strobes mark each bit and the final bit of each frame. It is the transmit end of the link whose receive end is the team's serial-in shift register, and it supports back-to-back words with no idle bubble.

## Interface

Parameters:
- WIDTH, 4, data word width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_i  input  WIDTH  parallel word to transmit; sampled only on an accepted handshake.
- valid_i  input  1  data_i is valid.
- ready_o  output  1  block can accept a word this cycle; combinational.
- x_o  output  1  serial data bit; registered.
- x_valid_o  output  1  x_o carries a frame bit this cycle; registered.
- last_o  output  1  x_o is the final bit of the frame; registered.

## Operation

- Handshake: a word is accepted on a rising edge where `valid_i && ready_o`. `data_i` is captured into a WIDTH-bit shift register.
- FSM states:
  - IDLE: no frame in flight.
  - SHIFT: frame bits are on `x_o`.
- FSM transitions:
  - IDLE -> SHIFT on accept.
  - SHIFT -> SHIFT on a last-bit cycle with a new accept (back-to-back).
  - SHIFT -> IDLE on a last-bit cycle with no accept.
- Bit counter: width $clog2(WIDTH+2). Loaded with the frame length minus 1 on accept, decremented each SHIFT cycle. The last bit is flagged when the counter is 0.
- Frame length is WIDTH bits, or WIDTH+1 with parity (see Configuration).
- Bit order is MSB first: `data_i[WIDTH-1]` is the first bit, `data_i[0]` is the last data bit. A receiver shifting left with LSB insertion holds the original word after WIDTH valid bits.
- `ready_o` = !reset && (state==IDLE || last_o).
  - Busy mid-frame, so the word after the current one cannot load until the last-bit cycle.
  - While busy, `valid_i`/`data_i` are ignored, and the sender must hold them until accepted.
- Reset values (held while reset is high):
  - state = IDLE; counter = 0; shift register = 0.
  - `x_o`=0, `x_valid_o`=0, `last_o`=0, `ready_o`=0.
- Reset mid-frame: the frame is abandoned immediately and no further bits are emitted. After deassertion the block is in IDLE with `ready_o`=1.
- Outside a frame, `x_o` is driven 0.

## Timing

- Latency: a word accepted at edge N drives its first bit on `x_o` with `x_valid_o`=1 from edge N through edge N+1.
- Bit k (0-based) is present during cycle N+k.
- `last_o`=1 coincides with bit WIDTH-1 (or the parity bit when enabled).
- Throughput: with `valid_i` held high continuously, `x_valid_o` stays 1 without gaps. One word is transmitted per frame-length cycles.
- `ready_o` rises in the same cycle `last_o` rises. An accept at that edge makes the next frame's first bit follow the previous last bit on the very next cycle.
- On a last-bit cycle with no accept, `x_valid_o` and `last_o` are 0 from the following edge.

## Configuration

- Macro `PISO_PARITY_EN`.
- Defined:
  - An even-parity bit (XOR of all captured data bits) is appended after `data_i[0]`.
  - Frame length is WIDTH+1, and `last_o` marks the parity bit.
  - Parity is computed at accept time from `data_i`.
- Undefined:
  - Frame length is WIDTH, with no parity logic or storage.
  - `last_o` marks `data_i[0]`.

## Test plan

- Reset, then one word, WIDTH=4: hold reset 1 cycle; `x_o`, `x_valid_o`, `last_o` are 0 and `ready_o`=0. After deassertion `ready_o`=1. Send 4'b1011 -> `x_o` = 1,0,1,1 on the four cycles after accept, `x_valid_o`=1 throughout, `last_o`=1 only on the 4th bit, then IDLE with outputs 0.
- Back-to-back: `valid_i` held with 4'hA then 4'h5 -> 8 contiguous valid bits 1,0,1,0,0,1,0,1. `last_o` pulses on bits 4 and 8. `ready_o` is high only in the two last-bit cycles plus the initial idle cycle.
- Busy stall: assert `valid_i` with 4'hC one cycle after 4'h3 is accepted -> `ready_o`=0 for 3 cycles. 4'hC is accepted on the last-bit cycle of 4'h3 and follows with no gap. The `data_i` change during the stall does not corrupt 4'h3.
- Reset mid-frame: accept 4'hF, assert reset after 2 bits -> `x_valid_o` drops to 0 asynchronously and no remaining bits appear. After deassertion the next word 4'h9 is sent cleanly as 1,0,0,1.
- Parity build (`PISO_PARITY_EN`): 4'b0111 -> bits 0,1,1,1 then parity 1, with `last_o` on the 5th bit. 4'b0110 -> parity 0.
- Loopback: drive `x_o` into a 4-bit left-shifting SIPO, enabled by `x_valid_o`, across 30 random words (parity disabled) -> the SIPO value equals each sent word in the cycle after that word's `last_o`.
